instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 62 ++++++
 rtl/instr_fetch.sv | 111 +++++++++++
 tb/tb_instr_fetch.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: data width, reset
// defaults, fetch state encoding and an address alignment helper.
package instr_fetch_pkg;

    localparam int              XLEN          = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam int              BUF_DEPTH_DEF = 2;

    // RUN issues fetches; FLUSH waits for stale responses to drain.
    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } fetch_state_e;

    // Force an address onto a 4-byte boundary.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer with a flush input and an occupancy count.
// Head data is read straight from storage, so the head is visible the cycle
// after it is written.
module fetch_fifo
    import instr_fetch_pkg::*;
#(
    parameter int DEPTH = BUF_DEPTH_DEF,
    parameter int WIDTH = XLEN
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    // Writes into a full buffer and reads from an empty one are ignored.
    assign do_push   = push && (cnt != CW'(DEPTH));
    assign do_pop    = pop && (cnt != '0);
    assign head_data = mem[rd_ptr];
    assign count     = cnt;

    // Pointer and occupancy update; flush empties the buffer in one cycle.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage; cleared on reset so the head reads zero out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: fetch PC, request credit, stale-response flushing
// after redirects, and the instruction buffer that feeds decode.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; valid never depends on ready, and while valid is high and not
// accepted the payload (address) holds steady unless a redirect replaces it.
// Responses carry no ready; they arrive in request order.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
    parameter int              BUF_DEPTH = BUF_DEPTH_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    output fetch_state_e    state_dbg
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    fetch_state_e    state;
    logic [XLEN-1:0] fpc;
    logic [XLEN-1:0] hpc;
    logic [CW-1:0]   out_cnt;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   occ;
    logic [CW-1:0]   drop_next;
    logic [XLEN-1:0] redirect_tgt;
    logic            req_fire;
    logic            rsp_take;
    logic            buf_push;
    logic            inst_fire;

    assign redirect_tgt = word_align(redirect_pc);

    // Credit: never have more requests in flight plus buffered entries than
    // the buffer can hold, so every live response has a slot waiting.
    assign imem_req_valid = !rst && (state == RUN) && ((out_cnt + occ) < CW'(BUF_DEPTH));
    assign imem_req_addr  = fpc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response is only meaningful if something is outstanding (live or
    // stale); anything else is a protocol error and is ignored.
    assign rsp_take  = imem_rsp_valid && ((out_cnt != '0) || (drop_cnt != '0));
    assign buf_push  = rsp_take && (drop_cnt == '0) && !redirect_valid;

    assign inst_valid = (occ != '0);
    assign inst_pc    = hpc;
    assign inst_fire  = inst_valid && inst_ready && !redirect_valid;
    assign state_dbg  = state;

    // Everything still in flight after this cycle becomes stale on a redirect.
    assign drop_next = drop_cnt + out_cnt + CW'(req_fire) - CW'(rsp_take);

    fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (XLEN)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (buf_push),
        .push_data (imem_rsp_data),
        .pop       (inst_fire),
        .head_data (inst_data),
        .count     (occ)
    );

    // PC, credit and flush-state tracking; reset beats redirect, redirect
    // beats normal advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            fpc      <= RESET_PC;
            hpc      <= RESET_PC;
            out_cnt  <= '0;
            drop_cnt <= '0;
        end else if (redirect_valid) begin
            fpc      <= redirect_tgt;
            hpc      <= redirect_tgt;
            out_cnt  <= '0;
            drop_cnt <= drop_next;
            state    <= (drop_next != '0) ? FLUSH : RUN;
        end else begin
            if (req_fire)  fpc <= fpc + XLEN'(4);
            if (inst_fire) hpc <= hpc + XLEN'(4);
            case (state)
                RUN: begin
                    out_cnt <= out_cnt + CW'(req_fire) - CW'(rsp_take);
                end
                FLUSH: begin
                    drop_cnt <= drop_next;
                    if (drop_next == '0) state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a behavioural memory with random in-order latency,
// an epoch-tagged request log, and an expected-instruction queue.
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         redirect_valid;
    logic [31:0]  redirect_pc;
    logic         imem_req_valid;
    logic         imem_req_ready;
    logic [31:0]  imem_req_addr;
    logic         imem_rsp_valid;
    logic [31:0]  imem_rsp_data;
    logic         inst_valid;
    logic         inst_ready;
    logic [31:0]  inst_data;
    logic [31:0]  inst_pc;
    fetch_state_e state_dbg;

    instr_fetch #(.RESET_PC(RESET_PC), .BUF_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .state_dbg      (state_dbg)
    );

    // ---------------- model state ----------------
    int          n_pass   = 0;
    int          n_fail   = 0;
    int          n_checks = 0;
    logic [31:0] mem_q[$];   // in-flight response data, request order
    int          due_q[$];   // earliest cycle each response may return
    int          ep_q[$];    // epoch the request was issued in
    logic [31:0] exp_q[$];   // live instructions delivered, not yet consumed
    logic [31:0] req_log[$];
    int          cur_ep   = 0;
    int          live     = 0;   // live requests issued minus instructions consumed
    int          cyc      = 0;
    logic [31:0] exp_pc   = RESET_PC;
    logic [31:0] exp_req  = RESET_PC;
    bit          checks_on = 1'b0;
    bit          log_en    = 1'b0;
    int          ready_pct = 100;
    int          irdy_pct  = 100;
    int          rsp_pct   = 100;
    int          lat_min   = 1;
    int          lat_max   = 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int stale_pending();
        int n = 0;
        foreach (ep_q[i]) if (ep_q[i] != cur_ep) n++;
        return n;
    endfunction

    // ---------------- driver: one clock cycle ----------------
    task automatic step(input logic do_rst, input logic redir, input logic [31:0] rpc,
                        input logic spur);
        logic        rsp_real;
        int          rsp_ep;
        logic [31:0] rsp_d;
        logic        exp_rv;
        logic        req_fire;
        logic        inst_fire;
        rsp_real = 1'b0;
        rsp_ep   = -1;
        rsp_d    = '0;
        rst            = do_rst;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_req_ready = ($urandom_range(0, 99) < ready_pct);
        inst_ready     = ($urandom_range(0, 99) < irdy_pct);
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        if (!do_rst && mem_q.size() != 0 && due_q[0] <= cyc && $urandom_range(0, 99) < rsp_pct) begin
            rsp_real       = 1'b1;
            rsp_d          = mem_q[0];
            rsp_ep         = ep_q[0];
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = rsp_d;
        end else if (!do_rst && spur && mem_q.size() == 0) begin
            imem_rsp_valid = 1'b1;
        end
        #1;
        // expected outputs for this cycle
        exp_rv = !do_rst && (stale_pending() == 0) && (live < DEPTH);
        if (checks_on || do_rst) check("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
        if (checks_on) begin
            check("state", {31'b0, state_dbg}, (stale_pending() != 0) ? 32'd1 : 32'd0);
            check("inst_valid", {31'b0, inst_valid}, {31'b0, exp_q.size() != 0});
            check("inst_pc", inst_pc, exp_pc);
            if (inst_valid && exp_q.size() != 0) check("inst_data", inst_data, exp_q[0]);
            if (imem_req_valid && !do_rst) check("req_addr", imem_req_addr, exp_req);
        end
        // model update
        if (do_rst) begin
            mem_q.delete(); due_q.delete(); ep_q.delete(); exp_q.delete();
            cur_ep++;
            live    = 0;
            exp_pc  = RESET_PC;
            exp_req = RESET_PC;
            checks_on = 1'b1;
        end else begin
            req_fire  = imem_req_valid && imem_req_ready;
            inst_fire = inst_valid && inst_ready && !redir;
            if (rsp_real) begin
                void'(mem_q.pop_front()); void'(due_q.pop_front()); void'(ep_q.pop_front());
            end
            if (req_fire) begin
                mem_q.push_back($urandom);
                due_q.push_back(cyc + $urandom_range(lat_min, lat_max));
                ep_q.push_back(cur_ep);
                if (log_en) req_log.push_back(imem_req_addr);
            end
            if (redir) begin
                cur_ep++;
                exp_q.delete();
                live    = 0;
                exp_pc  = rpc & ~32'h3;
                exp_req = rpc & ~32'h3;
            end else begin
                if (rsp_real && rsp_ep == cur_ep) exp_q.push_back(rsp_d);
                if (inst_fire && exp_q.size() != 0) begin
                    void'(exp_q.pop_front());
                    exp_pc = exp_pc + 32'd4;
                    live--;
                end
                if (req_fire) begin
                    exp_req = exp_req + 32'd4;
                    live++;
                end
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0; inst_ready = 1'b0;

        // reset
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_inst_data", inst_data, 32'd0);
        check("rst_inst_pc", inst_pc, RESET_PC);

        // streaming, 1-cycle latency, decode always ready
        log_en = 1'b1;
        repeat (8) step(0, 0, 0, 0);
        log_en = 1'b0;
        check("first_req_count_ge4", {31'b0, req_log.size() >= 4}, 32'd1);
        for (int i = 0; i < 4 && i < req_log.size(); i++) check("first_req_addr", req_log[i], 32'(i * 4));

        // decode stall: buffer fills, requests stop, then resume
        irdy_pct = 0;
        repeat (10) step(0, 0, 0, 0);
        check("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("stall_inst_valid", {31'b0, inst_valid}, 32'd1);
        irdy_pct = 100;
        repeat (8) step(0, 0, 0, 0);

        // two requests outstanding then redirect to 0x100
        ready_pct = 0;
        step(0, 1, 32'h80, 0);
        repeat (6) step(0, 0, 0, 0);
        ready_pct = 100; irdy_pct = 0; lat_min = 3; lat_max = 3;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 32'h100, 0);
        check("redirect_flush_state", {31'b0, state_dbg}, {31'b0, FLUSH});
        irdy_pct = 100; lat_min = 1; lat_max = 1;
        repeat (8) step(0, 0, 0, 0);

        // redirect coinciding with request accept and response arrival
        repeat (3) step(0, 0, 0, 0);
        step(0, 1, 32'h300, 0);
        repeat (6) step(0, 0, 0, 0);

        // unaligned target, then address wrap
        step(0, 1, 32'h203, 0);
        check("align_req_addr", imem_req_addr, 32'h200);
        repeat (4) step(0, 0, 0, 0);
        step(0, 1, 32'hFFFF_FFF8, 0);
        repeat (6) step(0, 0, 0, 0);

        // spurious response while nothing is outstanding
        ready_pct = 0;
        repeat (6) step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        ready_pct = 100;
        repeat (4) step(0, 0, 0, 0);

        // reset with requests in flight and a full buffer
        irdy_pct = 0; lat_min = 3; lat_max = 3;
        repeat (6) step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        check("midrst_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("midrst_req_addr", imem_req_addr, RESET_PC);
        irdy_pct = 100; lat_min = 1; lat_max = 1;
        repeat (6) step(0, 0, 0, 0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if (n % 200 == 0) begin
                ready_pct = $urandom_range(30, 100);
                irdy_pct  = $urandom_range(20, 100);
                rsp_pct   = $urandom_range(40, 100);
                lat_min   = $urandom_range(1, 2);
                lat_max   = lat_min + $urandom_range(0, 3);
            end
            step(($urandom_range(0, 999) < 3), ($urandom_range(0, 99) < 4), $urandom,
                 ($urandom_range(0, 99) < 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
